// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK flip-flop bank with parallel load, registered edge flags and a
// settle counter, which is built only when JK_REG_BANK_STABLE_CNT_EN is defined.
module jk_reg_bank #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               CNT_W      = 8,
    parameter int               STABLE_THR = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic [CNT_W-1:0] stable_cnt,
    output logic             stable
);

    if (STABLE_THR > (1 << CNT_W) - 1) begin : g_thr_check
        $error("jk_reg_bank: STABLE_THR does not fit in CNT_W bits");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [WIDTH-1:0] w_q_next;
    logic             w_changed;

    // NOTE: assign the default first so every path through always_comb drives
    // w_q_next; a missing else would otherwise infer a latch.
    always_comb begin
        w_q_next = r_q;
        if (ld) begin
            w_q_next = d;
        end else if (en) begin
            // JK characteristic equation: 00 hold, 01 clear, 10 set, 11 toggle.
            w_q_next = (j & ~r_q) | (~k & r_q);
        end
    end

    assign w_changed = |(r_q ^ w_q_next);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= RESET_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_rise    <= ~r_q & w_q_next;
            r_fall    <= r_q & ~w_q_next;
            r_changed <= w_changed;
        end
    end

    assign q       = r_q;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = r_changed;

`ifdef JK_REG_BANK_STABLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(STABLE_THR);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = '0;
        if (!w_changed) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    // stable is derived from the next count so it always matches the count it
    // is registered alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_stable <= (w_cnt_next >= THR);
        end
    end

    assign stable_cnt = r_cnt;
    assign stable     = r_stable;
`else
    assign stable_cnt = '0;
    assign stable     = 1'b0;
`endif

endmodule
